// File: rtl/apb_i2c_pkg.sv
// Shared register-map constants for the APB-side I2C register block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package apb_i2c_pkg;

  // 3-bit APB register addresses
  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd1;
  localparam logic [2:0] ADDR_SADDR    = 3'd2;
  localparam logic [2:0] ADDR_TXDATA   = 3'd3;
  localparam logic [2:0] ADDR_RXDATA   = 3'd4;
  localparam logic [2:0] ADDR_LEN      = 3'd5;
  localparam logic [2:0] ADDR_PRESCALE = 3'd6;
  localparam logic [2:0] ADDR_RSVD     = 3'd7;

  // CTRL bit positions
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_START  = 2;

  // STATUS bit positions
  localparam int ST_BUSY     = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_RX_EMPTY = 4;
  localparam int ST_DONE     = 5;
  localparam int ST_ACK_ERR  = 6;
  localparam int ST_OVF      = 7;

endpackage

// File: rtl/i2c_byte_fifo.sv
// Synchronous byte FIFO with combinational head (reads 0 when empty).
// Latency: push visible at the head one cycle after the push edge.
// Backpressure: push while full is accepted only together with a pop; otherwise ignored.
module i2c_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       reset_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  // a pop frees the slot the push lands in, so a full FIFO still accepts a push paired with a pop
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_head    = o_empty ? 8'h00 : r_mem[r_rd_ptr];

  // storage write; contents need no reset because the head is gated by empty
  always_ff @(posedge clk_i) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // wrapping pointers and occupancy count
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push_ok && w_pop_ok) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/apb_i2c_regs.sv
// APB register block for the I2C master: config regs, TX/RX byte FIFOs, sticky status, irq.
// Latency: zero-wait-state APB; start_o and irq_o are registered (one cycle after their cause).
// Backpressure: none on APB; full-FIFO pushes and empty RXDATA reads are dropped and flagged as ovf.
module apb_i2c_regs
  import apb_i2c_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] PRESCALE_RST = 8'd100
) (
  input  logic       clk_i,
  input  logic       reset_n,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [2:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       enable_o,
  output logic       start_o,
  output logic [6:0] slv_addr_o,
  output logic       rw_o,
  output logic [7:0] len_o,
  output logic [7:0] prescale_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       busy_i,
  input  logic       done_i,
  input  logic       ack_err_i,
  output logic       irq_o
);

  // configuration and status state
  logic       r_enable;
  logic       r_irq_en;
  logic       r_start;
  logic [7:0] r_saddr;
  logic [7:0] r_len;
  logic [7:0] r_prescale;
  logic       r_done;
  logic       r_ack_err;
  logic       r_ovf;
  logic       r_irq;

  // APB decode
  logic w_acc;
  logic w_wr;
  logic w_rd;
  logic w_wr_ctrl;
  logic w_wr_status;
  logic w_wr_saddr;
  logic w_wr_txdata;
  logic w_wr_len;
  logic w_wr_prescale;
  logic w_rd_rxdata;

  // FIFO status
  logic [7:0] w_tx_head;
  logic       w_tx_full;
  logic       w_tx_empty;
  logic       w_tx_pop;
  logic [7:0] w_rx_head;
  logic       w_rx_full;
  logic       w_rx_empty;

  // overflow / underflow sources
  logic w_tx_drop;
  logic w_rx_drop;
  logic w_rx_under;
  logic w_ovf_set;

  logic [7:0] w_status;
  logic       w_start_ok;

  assign w_acc         = psel & penable;
  assign w_wr          = w_acc & pwrite;
  assign w_rd          = w_acc & ~pwrite;
  assign w_wr_ctrl     = w_wr & (paddr == ADDR_CTRL);
  assign w_wr_status   = w_wr & (paddr == ADDR_STATUS);
  assign w_wr_saddr    = w_wr & (paddr == ADDR_SADDR);
  assign w_wr_txdata   = w_wr & (paddr == ADDR_TXDATA);
  assign w_wr_len      = w_wr & (paddr == ADDR_LEN);
  assign w_wr_prescale = w_wr & (paddr == ADDR_PRESCALE);
  assign w_rd_rxdata   = w_rd & (paddr == ADDR_RXDATA);

  assign pready = w_acc;

  assign w_tx_pop = ~w_tx_empty & tx_ready_i;

  i2c_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .i_push  (w_wr_txdata),
    .i_data  (pwdata),
    .i_pop   (w_tx_pop),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  // the FIFO itself ignores a pop on empty, so the RXDATA read strobe is passed straight through
  i2c_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .i_push  (rx_valid_i),
    .i_data  (rx_data_i),
    .i_pop   (w_rd_rxdata),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // a push into a full FIFO survives only when the same cycle pops
  assign w_tx_drop  = w_wr_txdata & w_tx_full & ~w_tx_pop;
  assign w_rx_drop  = rx_valid_i & w_rx_full & ~w_rd_rxdata;
  assign w_rx_under = w_rd_rxdata & w_rx_empty;
  assign w_ovf_set  = w_tx_drop | w_rx_drop | w_rx_under;

  assign w_status = {r_ovf, r_ack_err, r_done, w_rx_empty, w_rx_full,
                     w_tx_empty, w_tx_full, busy_i};

  // start is judged against the enable already in force, not the value being written
  assign w_start_ok = w_wr_ctrl & pwdata[CTRL_START] & r_enable & ~busy_i;

  // read mux: only drives data during a read access phase
  always_comb begin
    prdata = 8'h00;
    if (w_rd) begin
      case (paddr)
        ADDR_CTRL:     prdata = {6'b0, r_irq_en, r_enable};
        ADDR_STATUS:   prdata = w_status;
        ADDR_SADDR:    prdata = r_saddr;
        ADDR_RXDATA:   prdata = w_rx_head;
        ADDR_LEN:      prdata = r_len;
        ADDR_PRESCALE: prdata = r_prescale;
        default:       prdata = 8'h00;
      endcase
    end
  end

  // RW configuration registers
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_enable   <= 1'b0;
      r_irq_en   <= 1'b0;
      r_saddr    <= 8'h00;
      r_len      <= 8'h00;
      r_prescale <= PRESCALE_RST;
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= pwdata[CTRL_ENABLE];
        r_irq_en <= pwdata[CTRL_IRQ_EN];
      end
      if (w_wr_saddr) begin
        r_saddr <= pwdata;
      end
      if (w_wr_len) begin
        r_len <= pwdata;
      end
      if (w_wr_prescale) begin
        r_prescale <= pwdata;
      end
    end
  end

  // single-cycle start pulse, the cycle after the CTRL write
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_start <= 1'b0;
    end else begin
      r_start <= w_start_ok;
    end
  end

  // sticky flags: a new event in the same cycle as its W1C clear keeps the flag set
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done    <= done_i    | (r_done    & ~(w_wr_status & pwdata[ST_DONE]));
      r_ack_err <= ack_err_i | (r_ack_err & ~(w_wr_status & pwdata[ST_ACK_ERR]));
      r_ovf     <= w_ovf_set | (r_ovf     & ~(w_wr_status & pwdata[ST_OVF]));
    end
  end

  // registered interrupt level, one cycle behind the flags
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en & (r_done | r_ack_err | r_ovf);
    end
  end

  assign enable_o   = r_enable;
  assign start_o    = r_start;
  assign slv_addr_o = r_saddr[6:0];
  assign rw_o       = r_saddr[7];
  assign len_o      = r_len;
  assign prescale_o = r_prescale;
  assign tx_data_o  = w_tx_head;
  assign tx_valid_o = ~w_tx_empty;
  assign irq_o      = r_irq;

endmodule

// File: tb/tb_apb_i2c_regs.sv
// Self-checking bench for apb_i2c_regs: register tables, hand sequences, randomized FIFO traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_apb_i2c_regs;

  localparam int DEPTH = 4;

  logic       clk_i = 1'b0;
  logic       reset_n = 1'b0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [2:0] paddr = 3'd0;
  logic [7:0] pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pready;
  logic       enable_o;
  logic       start_o;
  logic [6:0] slv_addr_o;
  logic       rw_o;
  logic [7:0] len_o;
  logic [7:0] prescale_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_valid_i = 1'b0;
  logic       busy_i = 1'b0;
  logic       done_i = 1'b0;
  logic       ack_err_i = 1'b0;
  logic       irq_o;

  apb_i2c_regs #(.FIFO_DEPTH(DEPTH), .PRESCALE_RST(8'd100)) dut (
    .clk_i(clk_i), .reset_n(reset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .enable_o(enable_o), .start_o(start_o), .slv_addr_o(slv_addr_o), .rw_o(rw_o),
    .len_o(len_o), .prescale_o(prescale_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .busy_i(busy_i), .done_i(done_i), .ack_err_i(ack_err_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One APB transfer; side-band engine inputs are held only during the access cycle.
  task automatic apb(input logic wr, input logic [2:0] a, input logic [7:0] d,
                     input logic s_txr, input logic s_rxv, input logic [7:0] s_rxd,
                     input logic s_done, output logic [7:0] rd, output logic rdy);
    @(negedge clk_i);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk_i);
    penable = 1'b1; tx_ready_i = s_txr; rx_valid_i = s_rxv; rx_data_i = s_rxd; done_i = s_done;
    #1;
    rd = prdata;
    rdy = pready;
    @(negedge clk_i);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tx_ready_i = 1'b0; rx_valid_i = 1'b0; done_i = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] x;
    logic r;
    apb(1'b1, a, d, 1'b0, 1'b0, 8'h00, 1'b0, x, r);
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] x;
    logic r;
    apb(1'b0, a, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, x, r);
    chk(nm, 32'(x), 32'(exp));
    chk({nm, "_pready"}, 32'(r), 1);
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(negedge clk_i);
    rx_valid_i = 1'b1; rx_data_i = d;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  typedef struct {
    logic [2:0] a;
    logic [7:0] exp;
  } rvec_t;

  typedef struct {
    logic [2:0] a;
    logic [7:0] wd;
    logic [7:0] exp;
  } wvec_t;

  rvec_t rt[8];
  wvec_t wt[6];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic       ovf;
    logic [7:0] x;
    logic [7:0] e;
    logic       r;
    logic [7:0] bytes5[5];

    rt[0] = '{3'd0, 8'h00}; rt[1] = '{3'd1, 8'h14}; rt[2] = '{3'd2, 8'h00};
    rt[3] = '{3'd3, 8'h00}; rt[4] = '{3'd4, 8'h00}; rt[5] = '{3'd5, 8'h00};
    rt[6] = '{3'd6, 8'd100}; rt[7] = '{3'd7, 8'h00};

    wt[0] = '{3'd2, 8'h5A, 8'h5A}; wt[1] = '{3'd5, 8'h33, 8'h33};
    wt[2] = '{3'd6, 8'h07, 8'h07}; wt[3] = '{3'd7, 8'hFF, 8'h00};
    wt[4] = '{3'd0, 8'h02, 8'h02}; wt[5] = '{3'd0, 8'h00, 8'h00};

    bytes5[0] = 8'hA1; bytes5[1] = 8'hB2; bytes5[2] = 8'hC3; bytes5[3] = 8'hD4; bytes5[4] = 8'hE5;

    // reset state
    #12;
    chk("rst_outputs", 32'({enable_o, start_o, slv_addr_o, rw_o, len_o, tx_data_o,
                            tx_valid_o, irq_o, pready, prdata}), 0);
    chk("rst_prescale", 32'(prescale_o), 100);
    @(negedge clk_i);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) rd_chk($sformatf("reset_read_a%0d", i), rt[i].a, rt[i].exp);
    // the RXDATA read of an empty FIFO above flags ovf
    rd_chk("underflow_ovf", 3'd1, 8'h94);
    wr(3'd1, 8'h80);
    rd_chk("ovf_w1c", 3'd1, 8'h14);

    for (int i = 0; i < 6; i++) begin
      wr(wt[i].a, wt[i].wd);
      rd_chk($sformatf("readback_%0d", i), wt[i].a, wt[i].exp);
    end
    chk("prescale_o", 32'(prescale_o), 'h07);

    // start pulse
    wr(3'd0, 8'h01);
    wr(3'd2, 8'h50);
    wr(3'd5, 8'h02);
    wr(3'd0, 8'h05);
    chk("start_hi", 32'(start_o), 1);
    chk("cfg_out", 32'({enable_o, slv_addr_o, rw_o, len_o}), 32'({1'b1, 7'h50, 1'b0, 8'h02}));
    @(negedge clk_i);
    chk("start_one_cycle", 32'(start_o), 0);
    rd_chk("ctrl_start_reads0", 3'd0, 8'h01);
    busy_i = 1'b1;
    wr(3'd0, 8'h05);
    chk("start_busy_suppr", 32'(start_o), 0);
    rd_chk("status_busy", 3'd1, 8'h15);
    busy_i = 1'b0;

    // TX overflow then drain
    for (int i = 0; i < 5; i++) wr(3'd3, bytes5[i]);
    rd_chk("tx_full_ovf", 3'd1, 8'h92);
    wr(3'd1, 8'h80);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      tx_ready_i = 1'b1;
      #1;
      chk($sformatf("tx_drain_%0d", i), 32'({tx_valid_o, tx_data_o}), 32'({1'b1, bytes5[i]}));
    end
    @(negedge clk_i);
    tx_ready_i = 1'b0;
    #1;
    chk("tx_empty_after", 32'(tx_valid_o), 0);

    // push while full with a simultaneous pop
    for (int i = 1; i <= 4; i++) wr(3'd3, 8'(i));
    apb(1'b1, 3'd3, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, x, r);
    rd_chk("tx_full_pushpop", 3'd1, 8'h12);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk_i);
      tx_ready_i = 1'b1;
      #1;
      chk($sformatf("tx_pp_%0d", i), 32'(tx_data_o), i);
    end
    @(negedge clk_i);
    tx_ready_i = 1'b0;

    // RX path
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    rd_chk("rx_0", 3'd4, 8'h11);
    rd_chk("rx_1", 3'd4, 8'h22);
    rd_chk("rx_empty_read", 3'd4, 8'h00);
    rd_chk("rx_under_ovf", 3'd1, 8'h94);
    wr(3'd1, 8'h80);
    rd_chk("rx_ovf_clr", 3'd1, 8'h14);
    for (int i = 1; i <= 4; i++) rx_pulse(8'h30 + 8'(i));
    rd_chk("rx_full", 3'd1, 8'h0C);
    apb(1'b0, 3'd4, 8'h00, 1'b0, 1'b1, 8'h35, 1'b0, x, r);
    chk("rx_full_popread", 32'(x), 'h31);
    rd_chk("rx_full_push_ok", 3'd1, 8'h0C);
    rx_pulse(8'h36);
    rd_chk("rx_full_drop", 3'd1, 8'h8C);
    for (int i = 2; i <= 5; i++) rd_chk($sformatf("rx_order_%0d", i), 3'd4, 8'h30 + 8'(i));
    wr(3'd1, 8'h80);

    // done / irq timing and set-beats-clear
    wr(3'd0, 8'h03);
    @(negedge clk_i);
    done_i = 1'b1;
    @(negedge clk_i);
    done_i = 1'b0;
    chk("irq_lag", 32'(irq_o), 0);
    @(negedge clk_i);
    chk("irq_set", 32'(irq_o), 1);
    apb(1'b1, 3'd1, 8'h20, 1'b0, 1'b0, 8'h00, 1'b1, x, r);
    rd_chk("done_set_wins", 3'd1, 8'h34);
    wr(3'd1, 8'h20);
    @(negedge clk_i);
    chk("irq_clr", 32'(irq_o), 0);
    @(negedge clk_i);
    ack_err_i = 1'b1;
    @(negedge clk_i);
    ack_err_i = 1'b0;
    rd_chk("ack_err_flag", 3'd1, 8'h54);
    chk("irq_ack", 32'(irq_o), 1);
    wr(3'd1, 8'h40);
    wr(3'd0, 8'h01);
    @(negedge clk_i);
    done_i = 1'b1;
    @(negedge clk_i);
    done_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("irq_masked", 32'(irq_o), 0);
    wr(3'd1, 8'h20);

    // randomized FIFO traffic against a queue model
    ovf = 1'b0;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          e = 8'($urandom);
          wr(3'd3, e);
          if (txq.size() < DEPTH) txq.push_back(e);
          else ovf = 1'b1;
        end
        1: begin
          apb(1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, x, r);
          if (rxq.size() > 0) e = rxq.pop_front();
          else begin e = 8'h00; ovf = 1'b1; end
          chk("rand_rxdata", 32'(x), 32'(e));
        end
        2: begin
          for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
            @(negedge clk_i);
            rx_valid_i = 1'($urandom);
            rx_data_i = 8'($urandom);
            if (rx_valid_i) begin
              if (rxq.size() < DEPTH) rxq.push_back(rx_data_i);
              else ovf = 1'b1;
            end
          end
          @(negedge clk_i);
          rx_valid_i = 1'b0;
        end
        3: begin
          for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
            @(negedge clk_i);
            tx_ready_i = 1'($urandom);
            #1;
            chk("rand_tx_valid", 32'(tx_valid_o), 32'(txq.size() != 0));
            if (txq.size() != 0) begin
              chk("rand_tx_data", 32'(tx_data_o), 32'(txq[0]));
              if (tx_ready_i) void'(txq.pop_front());
            end
          end
          @(negedge clk_i);
          tx_ready_i = 1'b0;
        end
        default: begin
          e = {ovf, 2'b00, rxq.size() == 0, rxq.size() == DEPTH,
               txq.size() == 0, txq.size() == DEPTH, 1'b0};
          apb(1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, x, r);
          chk("rand_status", 32'(x), 32'(e));
          if (ovf) begin
            wr(3'd1, 8'h80);
            ovf = 1'b0;
          end
        end
      endcase
    end

    // asynchronous reset with TX bytes queued
    @(negedge clk_i);
    tx_ready_i = 1'b1;
    repeat (DEPTH) @(negedge clk_i);
    tx_ready_i = 1'b0;
    wr(3'd0, 8'h01);
    wr(3'd6, 8'h42);
    for (int i = 0; i < 3; i++) wr(3'd3, 8'h70 + 8'(i));
    chk("pre_rst_q", 32'({tx_valid_o, enable_o}), 'h3);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out", 32'({tx_valid_o, enable_o}), 0);
    chk("async_rst_prescale", 32'(prescale_o), 100);
    @(negedge clk_i);
    reset_n = 1'b1;
    rd_chk("post_rst_status", 3'd1, 8'h14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_i2c_regs.md
Name: apb_i2c_regs

Overview:
APB slave register block that sits between the APB bus interface and the I2C master engine. It decodes the 3-bit APB address space and holds the control and configuration registers. It buffers transmit and receive bytes in two small FIFOs and drives a start/stream handshake to the downstream I2C engine. It also collects engine status into sticky flags and an interrupt output.

Parameters:
FIFO_DEPTH, 4, entries per TX and RX FIFO (power of 2, >=2)
PRESCALE_RST, 8'd100, reset value of the PRESCALE register

Ports:
clk_i  in  1  clock
reset_n  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable (access phase)
pwrite  in  1  1=write, 0=read
paddr  in  3  register address
pwdata  in  8  write data
prdata  out  8  read data
pready  out  1  transfer complete
enable_o  out  1  I2C engine enable (CTRL[0])
start_o  out  1  one-cycle transaction start pulse
slv_addr_o  out  7  target address (SADDR[6:0])
rw_o  out  1  1=read transaction (SADDR[7])
len_o  out  8  byte count (LEN)
prescale_o  out  8  SCL divider (PRESCALE)
tx_data_o  out  8  TX FIFO head
tx_valid_o  out  1  TX FIFO non-empty
tx_ready_i  in  1  engine consumes tx_data_o this cycle
rx_data_i  in  8  received byte
rx_valid_i  in  1  rx_data_i valid, single cycle
busy_i  in  1  engine mid-transaction
done_i  in  1  one-cycle transaction-complete pulse
ack_err_i  in  1  one-cycle NACK pulse
irq_o  out  1  interrupt, level

Behaviour:
- Reset (reset_n low, async): registers 0, PRESCALE=PRESCALE_RST, FIFOs empty, sticky flags 0. All outputs 0 except prescale_o=PRESCALE_RST.
- APB: zero wait states. pready=psel&penable. Write takes effect on the clock edge where psel&penable&pwrite. Read: prdata is combinational from the addressed register while psel&penable&!pwrite, and 8'h00 otherwise.
- Register map:
  - 0 CTRL RW: [0] enable, [1] irq_en, [2] start. Start is write-only and reads 0.
  - 1 STATUS: [0] busy_i, [1] tx_full, [2] tx_empty, [3] rx_full, [4] rx_empty, [5] done sticky, [6] ack_err sticky, [7] ovf sticky. Bits 5-7 are W1C; other bits are RO.
  - 2 SADDR RW.
  - 3 TXDATA WO: a write pushes to the TX FIFO. Reads return 0.
  - 4 RXDATA RO: a read returns the RX head and pops it in the same access.
  - 5 LEN RW.
  - 6 PRESCALE RW.
  - 7 reserved: reads 0, writes ignored.
- start_o: writing CTRL with pwdata[2]=1 pulses start_o high for exactly one cycle, the cycle after the write edge. The pulse is suppressed if busy_i=1 or enable=0 at the write edge.
- TX FIFO:
  - Pop when tx_valid_o&tx_ready_i.
  - Push when full: byte dropped, ovf set.
  - Simultaneous push and pop when full: both accepted, count unchanged.
  - Push to empty: tx_valid_o rises next cycle.
- RX FIFO:
  - Push on rx_valid_i.
  - rx_valid_i when full: byte dropped, ovf set, unless an RXDATA read pops in the same cycle, in which case the push is accepted.
  - RXDATA read when empty: prdata=0, no pop, ovf set.
- Sticky flags: done set on done_i, ack_err set on ack_err_i. If a set and a W1C clear land on the same cycle, set wins.
- irq_o = irq_en & (done | ack_err | ovf), registered, so it trails the flag by one cycle.
- Clearing enable does not flush the FIFOs. Reset mid-transaction flushes both FIFOs and drops enable_o immediately (asynchronous).
- FIFO pointers: log2(FIFO_DEPTH) bits, wrapping. Count: log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package apb_i2c_pkg:
  - address localparams ADDR_CTRL..ADDR_PRESCALE (3-bit).
  - STATUS bit index localparams.
  - CTRL bit index localparams.
- Sub-module i2c_byte_fifo (sync FIFO, 8-bit, parameter DEPTH) with push/pop/full/empty/head. Instantiated twice.

Test Plan:
- Reset then read all 8 addresses:
  - PRESCALE=8'd100.
  - STATUS=8'h14 (tx_empty, rx_empty).
  - All others 0.
  - pready=1 in every access phase.
- Set enable (CTRL=8'h01), write SADDR=8'h50, LEN=8'h02, then write CTRL=8'h05 with busy_i=0:
  - start_o high exactly one cycle.
  - slv_addr_o=7'h50, rw_o=0, len_o=2.
  - Repeat with busy_i=1: no pulse.
- Write TXDATA 0xA1,0xB2,0xC3,0xD4,0xE5 (DEPTH=4), tx_ready_i=0:
  - STATUS[1]=1, STATUS[7]=1.
  - Then tx_ready_i=1: tx_data_o sequence A1,B2,C3,D4, then tx_valid_o=0.
- Drive rx_valid_i with 0x11, 0x22, then read RXDATA three times:
  - Returns 0x11, 0x22, 0x00.
  - Third read sets STATUS[7].
  - Write STATUS=8'h80: clears it.
- CTRL=8'h03, pulse done_i:
  - irq_o=1 two cycles after done_i.
  - Write STATUS=8'h20 in the same cycle as a new done_i: done stays 1.
- Assert reset_n low mid-stream with 3 TX bytes queued:
  - tx_valid_o=0 and enable_o=0 immediately.
  - STATUS=8'h14 after release.
